dsp_pipe_flow_ctrl: RTL and testbench

Flow-control and result-capture stage at the output end of the DSP48A1 slice pipeline. It generates the shared clock-enable that drives every optional pipeline register and tracks a valid bit alongside each operand set through those registers. It captures each valid P result into a 2-entry output buffer and presents it on a ready/valid interface. Downstream backpressure therefore stalls the whole slice losslessly instead of dropping results.

---
 rtl/dsp_pipe_flow_ctrl.sv | 150 +++++++++++++++
 tb/tb_dsp_pipe_flow_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// dsp_pipe_flow_ctrl
//
// Flow-control and result-capture stage at the output end of the DSP48A1
// slice pipeline. It drives one shared clock-enable into every optional slice
// pipeline register (A/B/C/D/M/P). Alongside that enable it moves a valid bit
// through a shadow pipeline, so each operand set has a matching valid flag.
//
// When a valid result reaches the slice output, it is captured into a 2-entry
// buffer and offered on a ready/valid interface. The enable is taken away when
// the buffer is full. Downstream backpressure therefore freezes the whole
// slice instead of dropping results.
//
// Parameters
//   LATENCY   number of enabled pipeline stages between operands and P (0..4)
//   P_WIDTH   width of the P result
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set presented to the slice this cycle
//   in_ready   operand set accepted when in_valid && in_ready (same as ce_out)
//   ce_out     clock-enable for every slice pipeline register
//   p_in       P result from the slice output
//   out_valid  out_data holds a valid result
//   out_ready  downstream takes the result when out_valid && out_ready
//   out_data   head entry of the output buffer
//   idle       nothing in flight and the output buffer is empty
// -----------------------------------------------------------------------------
module dsp_pipe_flow_ctrl #(
  parameter int LATENCY = 2,
  parameter int P_WIDTH = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               ce_out,
  input  logic [P_WIDTH-1:0] p_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_data,
  output logic               idle
);

  // Configuration guard: the slice only has stages for 0..4 enabled registers.
  if ((LATENCY < 0) || (LATENCY > 4)) begin : g_bad_latency
    $error("dsp_pipe_flow_ctrl: LATENCY must be within 0..4");
  end

  // Output buffer state
  logic [1:0]         r_count;
  logic               r_wptr;
  logic               r_rptr;
  logic [P_WIDTH-1:0] r_mem [2];

  // Handshake and pipeline status
  logic w_ce;
  logic w_rv;
  logic w_pipe_busy;
  logic w_push;
  logic w_pop;

  // The enable depends only on the count register. Because of that, the
  // enable has no combinational path from out_ready, in_valid or p_in. A full
  // buffer stalls the slice in the same cycle that the count reaches 2.
  assign w_ce = (r_count != 2'd2);

  // Capture the slice result when a valid slot leaves the last stage while
  // the slice is advancing. Hand the head entry out when downstream takes it.
  assign w_push = w_rv & w_ce;
  assign w_pop  = out_valid & out_ready;

  // Valid tracker: shadows the enabled slice registers one-for-one.
  if (LATENCY == 0) begin : g_lat0
    // With no registers, the result comes straight from this cycle's operands.
    assign w_rv        = in_valid;
    assign w_pipe_busy = 1'b0;
  end else begin : g_latn
    logic [LATENCY-1:0] r_vpipe;

    // Shift the valid bits on every enabled cycle and hold them on a stall.
    // Bubbles travel through the pipeline as zeros.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vpipe <= '0;
      end else if (w_ce) begin
        r_vpipe[0] <= in_valid;
        for (int k = 1; k < LATENCY; k++) begin
          r_vpipe[k] <= r_vpipe[k-1];
        end
      end else begin
        r_vpipe <= r_vpipe;
      end
    end

    assign w_rv        = r_vpipe[LATENCY-1];
    assign w_pipe_busy = |r_vpipe;
  end

  // Occupancy count. A push and a pop in the same cycle leave the count as it
  // is. A push can never arrive when the count is 2, because the enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write pointer and buffer storage. The entries clear on reset so that
  // out_data reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= p_in;
      r_wptr        <= ~r_wptr;
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer: moves to the next entry on each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr <= 1'b0;
    end else if (w_pop) begin
      r_rptr <= ~r_rptr;
    end else begin
      r_rptr <= r_rptr;
    end
  end

  // Every output is decoded from registered state only. There is no bypass,
  // so a freshly pushed result appears on the next cycle.
  assign ce_out    = w_ce;
  assign in_ready  = w_ce;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rptr];
  assign idle      = (r_count == 2'd0) & ~w_pipe_busy;

endmodule

// File: tb/tb_dsp_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dsp_pipe_flow_ctrl. Three instances (LATENCY 2, 3
// and 0) each drive a small behavioural slice model that passes operand
// values through as P results. The model's registers are gated by the DUT's
// ce_out.
// -----------------------------------------------------------------------------
module tb_dsp_pipe_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // LATENCY = 2 instance
  logic        iv2, ir2, ce2, ov2, ordy2, idle2;
  logic [47:0] op2, p2, od2, s2_0, s2_1;
  // LATENCY = 3 instance
  logic        iv3, ir3, ce3, ov3, ordy3, idle3;
  logic [47:0] op3, p3, od3, s3_0, s3_1, s3_2;
  // LATENCY = 0 instance
  logic        iv0, ir0, ce0, ov0, ordy0, idle0;
  logic [47:0] op0, od0;

  dsp_pipe_flow_ctrl #(.LATENCY(2), .P_WIDTH(48)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .ce_out(ce2),
    .p_in(p2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .idle(idle2));

  dsp_pipe_flow_ctrl #(.LATENCY(3), .P_WIDTH(48)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .ce_out(ce3),
    .p_in(p3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .idle(idle3));

  dsp_pipe_flow_ctrl #(.LATENCY(0), .P_WIDTH(48)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .ce_out(ce0),
    .p_in(op0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .idle(idle0));

  // Slice model, two enabled stages
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_0 <= 48'd0;
      s2_1 <= 48'd0;
    end else if (ce2) begin
      s2_0 <= op2;
      s2_1 <= s2_0;
    end
  end
  assign p2 = s2_1;

  // Slice model, three enabled stages
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_0 <= 48'd0;
      s3_1 <= 48'd0;
      s3_2 <= 48'd0;
    end else if (ce3) begin
      s3_0 <= op3;
      s3_1 <= s3_0;
      s3_2 <= s3_1;
    end
  end
  assign p3 = s3_2;

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the LATENCY=2 outputs for the current cycle, drive the next inputs,
  // then advance one cycle (negedge to negedge).
  task automatic cyc2(input string tag, input logic iv, input logic [47:0] op,
                      input logic ordy, input logic eov, input logic [47:0] ed,
                      input logic ece, input logic eidle);
    check_eq({tag, "_ov"}, 48'(ov2), 48'(eov));
    if (eov) check_eq({tag, "_data"}, od2, ed);
    check_eq({tag, "_ce"}, 48'(ce2), 48'(ece));
    check_eq({tag, "_rdy"}, 48'(ir2), 48'(ece));
    check_eq({tag, "_idle"}, 48'(idle2), 48'(eidle));
    iv2 = iv; op2 = op; ordy2 = ordy;
    @(negedge clk);
  endtask

  initial begin
    int bp_iv[12]   = '{1,1,1,1,1,1,1,1,0,0,0,0};
    int bp_op[12]   = '{11,12,13,14,15,15,15,15,0,0,0,0};
    int bp_rdy[12]  = '{0,0,0,0,0,0,1,1,1,1,1,1};
    int bp_ov[12]   = '{0,0,0,1,1,1,1,1,1,1,1,0};
    int bp_d[12]    = '{0,0,0,11,11,11,11,12,13,14,15,0};
    int bp_ce[12]   = '{1,1,1,1,0,0,0,1,1,1,1,1};
    int b3_iv[9]    = '{1,0,1,1,0,0,0,0,0};
    int b3_op[9]    = '{21,0,23,24,0,0,0,0,0};
    int b3_ov[9]    = '{0,0,0,0,1,0,1,1,0};
    int b3_d[9]     = '{0,0,0,0,21,0,23,24,0};
    int b3_idle[9]  = '{1,0,0,0,0,0,0,0,1};
    int npop3;
    logic [47:0] q[$];
    logic [47:0] exp_d;
    int acc, got, cyc;

    rst = 1'b1;
    iv2 = 1'b0; op2 = 48'd0; ordy2 = 1'b0;
    iv3 = 1'b0; op3 = 48'd0; ordy3 = 1'b1;
    iv0 = 1'b0; op0 = 48'd0; ordy0 = 1'b0;

    // Reset values
    #2;
    check_eq("rst_ov", 48'(ov2), 48'd0);
    check_eq("rst_data", od2, 48'd0);
    check_eq("rst_ce", 48'(ce2), 48'd1);
    check_eq("rst_rdy", 48'(ir2), 48'd1);
    check_eq("rst_idle", 48'(idle2), 48'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // LATENCY=0: result visible the cycle after acceptance
    check_eq("l0_ov0", 48'(ov0), 48'd0);
    check_eq("l0_idle0", 48'(idle0), 48'd1);
    iv0 = 1'b1; op0 = 48'h00000000ABCD;
    @(negedge clk);
    check_eq("l0_ov1", 48'(ov0), 48'd1);
    check_eq("l0_data", od0, 48'h00000000ABCD);
    check_eq("l0_ce", 48'(ce0), 48'd1);
    check_eq("l0_idle1", 48'(idle0), 48'd0);
    iv0 = 1'b0; op0 = 48'd0; ordy0 = 1'b1;
    @(negedge clk);
    check_eq("l0_ov2", 48'(ov0), 48'd0);
    check_eq("l0_idle2", 48'(idle0), 48'd1);
    ordy0 = 1'b0;

    // LATENCY=3 with bubbles: in_valid 1,0,1,1,0
    npop3 = 0;
    for (int c = 0; c < 9; c++) begin
      check_eq("bub_ov", 48'(ov3), 48'(b3_ov[c]));
      if (b3_ov[c] != 0) check_eq("bub_data", od3, 48'(b3_d[c]));
      check_eq("bub_idle", 48'(idle3), 48'(b3_idle[c]));
      check_eq("bub_ce", 48'(ce3), 48'd1);
      if (ov3) npop3++;
      iv3 = 1'(b3_iv[c]); op3 = 48'(b3_op[c]);
      @(negedge clk);
    end
    check_eq("bub_pops", 48'(npop3), 48'd3);

    // LATENCY=2 streaming: P=1..8, out_valid 3 cycles after first accept
    for (int c = 0; c < 12; c++) begin
      cyc2("str", 1'(c < 8), 48'(c + 1), 1'b1, 1'(c >= 3 && c <= 10),
           48'(c - 2), 1'b1, 1'(c == 0 || c == 11));
    end

    // Backpressure: out_ready low while five operands stream in
    for (int c = 0; c < 12; c++) begin
      cyc2("bp", 1'(bp_iv[c]), 48'(bp_op[c]), 1'(bp_rdy[c]), 1'(bp_ov[c]),
           48'(bp_d[c]), 1'(bp_ce[c]), 1'(c == 0 || c == 11));
    end

    // Fill to count=2 with vpipe busy, then reset asynchronously
    for (int c = 0; c < 4; c++) begin
      cyc2("fill", 1'b1, 48'(31 + c), 1'b0, 1'(c == 3), 48'd31, 1'b1, 1'(c == 0));
    end
    check_eq("fill_ce", 48'(ce2), 48'd0);
    check_eq("fill_ov", 48'(ov2), 48'd1);
    check_eq("fill_idle", 48'(idle2), 48'd0);
    iv2 = 1'b0; op2 = 48'd0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ov", 48'(ov2), 48'd0);
    check_eq("arst_data", od2, 48'd0);
    check_eq("arst_ce", 48'(ce2), 48'd1);
    check_eq("arst_idle", 48'(idle2), 48'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cyc2("post", 1'(c < 3), 48'(41 + c), 1'b1, 1'(c >= 3 && c <= 5),
           48'(38 + c), 1'b1, 1'(c == 0 || c == 6));
    end

    // Random out_ready with scoreboard over 1000 results
    acc = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      iv2 = 1'(acc < 1000);
      op2 = {16'($urandom), 32'($urandom)};
      ordy2 = 1'($urandom_range(0, 1));
      // Fewer than two outstanding results means the buffer cannot be full
      if (q.size() < 2) check_eq("rand_ce", 48'(ce2), 48'd1);
      if (iv2 && ir2) begin
        q.push_back(op2);
        acc++;
      end
      if (ov2 && ordy2) begin
        if (q.size() == 0) begin
          check_eq("rand_extra", od2, 48'd0);
          check_eq("rand_extra_ov", 48'(ov2), 48'd0);
        end else begin
          exp_d = q.pop_front();
          check_eq("rand_data", od2, exp_d);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    iv2 = 1'b0; ordy2 = 1'b0;
    check_eq("rand_count", 48'(got), 48'd1000);
    check_eq("rand_left", 48'(q.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
